// File: rtl/cpu_io_port_ctrl.sv
// Host-side I/O port controller for the CPU.
// Inbound bytes from the host queue in an RX FIFO. The head byte is presented on
// i_port, and int_sig asks the CPU's ISR to execute IN. Outbound OUT writes
// queue in a TX FIFO, which drains to the host.
//
// Handshakes: a byte moves on host_in_* or host_out_* only on a rising edge where
// valid and ready are both high. host_in_ready and host_out_valid depend only on
// registered FIFO counts. The CPU side has no backpressure: o_wr always writes,
// and in_ack always pops. An o_wr into a full TX FIFO is dropped and sets tx_ovf.
// An in_ack on an empty RX FIFO is ignored and sets rx_udf.
//
// irq_state exposes the interrupt FSM: 0 = IDLE, 1 = RAISE, 2 = WAIT.
module cpu_io_port_ctrl #(
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4,
    parameter int INT_LEN  = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] host_in_data,
    input  logic       host_in_valid,
    output logic       host_in_ready,
    output logic [7:0] i_port,
    input  logic       in_ack,
    output logic       int_sig,
    input  logic [7:0] o_port,
    input  logic       o_wr,
    output logic [7:0] host_out_data,
    output logic       host_out_valid,
    input  logic       host_out_ready,
    output logic       tx_ovf,
    output logic       rx_udf,
    output logic [1:0] irq_state
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam logic [3:0] INT_LEN_C = 4'(INT_LEN);

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_RAISE = 2'd1,
        IRQ_WAIT  = 2'd2
    } irq_state_e;

    // RX FIFO state
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_q, rx_rd_q;
    logic [RX_CW-1:0] rx_count_q, rx_count_d;
    logic             rx_full, rx_empty, rx_push, rx_pop;

    // TX FIFO state
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_q, tx_rd_q;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic             tx_full, tx_empty, tx_push, tx_pop;

    // Sticky error flags and interrupt FSM
    logic             tx_ovf_q, rx_udf_q;
    irq_state_e       state_q;
    logic [3:0]       cnt_q;
    logic             int_q, ack_q;

    // Full and empty come from the registered counts only, so a pop in the
    // same cycle never opens room for a push into a full FIFO.
    assign rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count_q == '0);
    assign rx_push  = host_in_valid & ~rx_full;
    assign rx_pop   = in_ack & ~rx_empty;

    assign tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count_q == '0);
    assign tx_push  = o_wr & ~tx_full;
    assign tx_pop   = ~tx_empty & host_out_ready;

    assign host_in_ready  = ~rx_full;
    assign i_port         = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q];
    assign host_out_valid = ~tx_empty;
    assign host_out_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];
    assign tx_ovf         = tx_ovf_q;
    assign rx_udf         = rx_udf_q;
    assign int_sig        = int_q;
    assign irq_state      = state_q;

    // Next FIFO occupancy; a simultaneous push and pop leaves the count unchanged
    always_comb begin
        rx_count_d = rx_count_q;
        if (rx_push && !rx_pop)      rx_count_d = rx_count_q + 1'b1;
        else if (!rx_push && rx_pop) rx_count_d = rx_count_q - 1'b1;
        tx_count_d = tx_count_q;
        if (tx_push && !tx_pop)      tx_count_d = tx_count_q + 1'b1;
        else if (!tx_push && tx_pop) tx_count_d = tx_count_q - 1'b1;
    end

    // FIFO storage; contents are don't-care while empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= host_in_data;
        if (tx_push) tx_mem_q[tx_wr_q] <= o_port;
    end

    // Pointers, counts and sticky flags; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_count_q <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
            if (o_wr && tx_full)    tx_ovf_q <= 1'b1;
            if (in_ack && rx_empty) rx_udf_q <= 1'b1;
        end
    end

    // Interrupt FSM. It raises int_sig for INT_LEN cycles, then waits for an RX pop as the acknowledge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IRQ_IDLE;
            cnt_q   <= '0;
            int_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (!rx_empty) begin
                        state_q <= IRQ_RAISE;
                        cnt_q   <= INT_LEN_C;
                        int_q   <= 1'b1;
                        ack_q   <= 1'b0;
                    end
                end
                IRQ_RAISE: begin
                    if (rx_pop) ack_q <= 1'b1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= IRQ_WAIT;
                        cnt_q   <= '0;
                        int_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                IRQ_WAIT: begin
                    if (ack_q || rx_pop) begin
                        ack_q <= 1'b0;
                        if (rx_count_d != '0) begin
                            state_q <= IRQ_RAISE;
                            cnt_q   <= INT_LEN_C;
                            int_q   <= 1'b1;
                        end else begin
                            state_q <= IRQ_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IRQ_IDLE;
                    cnt_q   <= '0;
                    int_q   <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_io_port_ctrl.sv
// Bench for cpu_io_port_ctrl. A queue-based reference model predicts every
// output each cycle. Directed steps are followed by a randomized phase.
module tb_cpu_io_port_ctrl;
    localparam int RX_DEPTH = 4;
    localparam int TX_DEPTH = 4;
    localparam int INT_LEN  = 2;

    // Clock and reset
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [7:0] host_in_data, i_port, o_port, host_out_data;
    logic       host_in_valid, host_in_ready, in_ack, int_sig, o_wr;
    logic       host_out_valid, host_out_ready, tx_ovf, rx_udf;
    logic [1:0] irq_state;

    cpu_io_port_ctrl #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .INT_LEN(INT_LEN)) dut (
        .clk(clk), .rstn(rstn),
        .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
        .i_port(i_port), .in_ack(in_ack), .int_sig(int_sig),
        .o_port(o_port), .o_wr(o_wr),
        .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
        .tx_ovf(tx_ovf), .rx_udf(rx_udf), .irq_state(irq_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as queues, interrupt as a pulse/await description
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    bit m_ovf, m_udf, m_high, m_wait, m_acked;
    int m_left;
    bit last_rx_push, last_tx_pop;
    logic [7:0] pre_tx_data, pre_i_port;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rx_exp_q.delete();
        tx_exp_q.delete();
        m_ovf = 0; m_udf = 0; m_high = 0; m_wait = 0; m_acked = 0; m_left = 0;
        last_rx_push = 0; last_tx_pop = 0;
    endtask

    task automatic model_edge();
        int  n_pre, t_pre;
        bit  rx_pop, rx_push, tx_pop, tx_push;
        logic [7:0] dummy;
        n_pre   = rx_exp_q.size();
        t_pre   = tx_exp_q.size();
        rx_pop  = in_ack && (n_pre != 0);
        rx_push = host_in_valid && (n_pre < RX_DEPTH);
        tx_pop  = (t_pre != 0) && host_out_ready;
        tx_push = o_wr && (t_pre < TX_DEPTH);
        if (in_ack && n_pre == 0) m_udf = 1;
        if (o_wr && t_pre == TX_DEPTH) m_ovf = 1;
        if (rx_pop)  dummy = rx_exp_q.pop_front();
        if (rx_push) rx_exp_q.push_back(host_in_data);
        if (tx_pop)  dummy = tx_exp_q.pop_front();
        if (tx_push) tx_exp_q.push_back(o_port);
        last_rx_push = rx_push;
        last_tx_pop  = tx_pop;
        // Interrupt: pulse INT_LEN cycles once data is present, then await a pop
        if (!m_high && !m_wait) begin
            if (n_pre != 0) begin
                m_high = 1; m_left = INT_LEN; m_acked = 0;
            end
        end else if (m_high) begin
            if (rx_pop) m_acked = 1;
            m_left--;
            if (m_left == 0) begin
                m_high = 0; m_wait = 1;
            end
        end else begin
            if (m_acked || rx_pop) begin
                m_acked = 0; m_wait = 0;
                if (rx_exp_q.size() != 0) begin
                    m_high = 1; m_left = INT_LEN;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_ip, exp_od;
        logic [1:0] exp_st;
        exp_ip = (rx_exp_q.size() != 0) ? rx_exp_q[0] : 8'h00;
        exp_od = (tx_exp_q.size() != 0) ? tx_exp_q[0] : 8'h00;
        exp_st = m_high ? 2'd1 : (m_wait ? 2'd2 : 2'd0);
        check("host_in_ready", 8'(host_in_ready), 8'(rx_exp_q.size() < RX_DEPTH));
        check("i_port", i_port, exp_ip);
        check("int_sig", 8'(int_sig), 8'(m_high));
        check("host_out_valid", 8'(host_out_valid), 8'(tx_exp_q.size() != 0));
        check("host_out_data", host_out_data, exp_od);
        check("tx_ovf", 8'(tx_ovf), 8'(m_ovf));
        check("rx_udf", 8'(rx_udf), 8'(m_udf));
        check("irq_state", 8'(irq_state), 8'(exp_st));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic step();
        pre_tx_data = host_out_data;
        pre_i_port  = i_port;
        @(posedge clk);
        if (rstn) model_edge();
        else      model_reset();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [7:0] b2b[5];
        logic [7:0] got[$];
        logic [7:0] sent[$];
        int  idx, hi;
        bit  prev_int, full_seen;

        // Reset held with active inputs: nothing may be captured
        rstn = 0; host_in_valid = 1; host_in_data = 8'h77; in_ack = 0;
        o_port = 8'h55; o_wr = 1; host_out_ready = 0;
        model_reset();
        repeat (3) step();
        check("rst_ready", 8'(host_in_ready), 8'h01);
        check("rst_out_valid", 8'(host_out_valid), 8'h00);
        host_in_valid = 0; o_wr = 0; rstn = 1;
        step();

        // Single inbound byte
        host_in_data = 8'hA5; host_in_valid = 1;
        step();
        host_in_valid = 0;
        check("single_iport", i_port, 8'hA5);
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (int_sig === 1'b1) hi++;
        end
        check("single_pulse_len", 8'(hi), 8'(INT_LEN));
        in_ack = 1;
        step();
        in_ack = 0;
        check("single_iport_after_ack", i_port, 8'h00);
        check("single_state_idle", 8'(irq_state), 8'h00);
        step(); step();
        check("single_int_quiet", 8'(int_sig), 8'h00);

        // Back-to-back inbound with the fifth byte held off by backpressure
        b2b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        idx = 0; prev_int = 0; full_seen = 0;
        for (int cyc = 0; cyc < 200 && got.size() < 5; cyc++) begin
            if (idx < 5) begin
                host_in_valid = 1; host_in_data = b2b[idx];
            end else begin
                host_in_valid = 0;
            end
            in_ack = (idx >= 4) && prev_int && !int_sig;
            if (in_ack) got.push_back(i_port);
            prev_int = int_sig;
            step();
            if (last_rx_push) idx++;
            if (idx == 4 && !full_seen) begin
                check("b2b_ready_full", 8'(host_in_ready), 8'h00);
                full_seen = 1;
            end
        end
        in_ack = 0; host_in_valid = 0;
        check("b2b_count", 8'(got.size()), 8'd5);
        for (int i = 0; i < 5; i++)
            check("b2b_order", (i < got.size()) ? got[i] : 8'hXX, b2b[i]);
        step(); step();
        check("b2b_idle", 8'(irq_state), 8'h00);

        // Outbound with the host stalling, then draining
        o_wr = 1; o_port = 8'h3C; step();
        o_port = 8'hC3; step();
        o_wr = 0;
        check("out_valid", 8'(host_out_valid), 8'h01);
        check("out_head", host_out_data, 8'h3C);
        host_out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_tx_pop) sent.push_back(pre_tx_data);
        end
        host_out_ready = 0;
        check("out_count", 8'(sent.size()), 8'd2);
        check("out_first", (sent.size() > 0) ? sent[0] : 8'hXX, 8'h3C);
        check("out_second", (sent.size() > 1) ? sent[1] : 8'hXX, 8'hC3);
        check("out_valid_fall", 8'(host_out_valid), 8'h00);

        // TX overflow: the fifth write is dropped
        for (int k = 1; k <= 5; k++) begin
            o_wr = 1; o_port = 8'(k);
            step();
        end
        o_wr = 0;
        check("ovf_set", 8'(tx_ovf), 8'h01);
        sent.delete();
        host_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_tx_pop) sent.push_back(pre_tx_data);
        end
        host_out_ready = 0;
        check("ovf_drain_count", 8'(sent.size()), 8'd4);
        for (int i = 0; i < 4; i++)
            check("ovf_drain_order", (i < sent.size()) ? sent[i] : 8'hXX, 8'(i + 1));
        check("ovf_sticky", 8'(tx_ovf), 8'h01);

        // RX underflow
        in_ack = 1; step(); in_ack = 0;
        check("udf_set", 8'(rx_udf), 8'h01);
        check("udf_iport", i_port, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            host_in_valid  = 1'($urandom_range(0, 1));
            host_in_data   = 8'($urandom);
            in_ack         = ($urandom_range(0, 3) == 0);
            o_wr           = ($urandom_range(0, 2) == 0);
            o_port         = 8'($urandom);
            host_out_ready = 1'($urandom_range(0, 1));
            step();
        end
        host_in_valid = 0; in_ack = 0; o_wr = 0; host_out_ready = 0;

        // Asynchronous reset in the middle of an interrupt pulse
        rstn = 0; step(); rstn = 1; step();
        host_in_data = 8'h5A; host_in_valid = 1; step(); host_in_valid = 0;
        o_wr = 1; o_port = 8'h99; step(); o_wr = 0;
        hi = 0;
        for (int i = 0; i < 10 && int_sig !== 1'b1; i++) begin
            step();
            hi++;
        end
        check("mid_pulse_int_high", 8'(int_sig), 8'h01);
        #2 rstn = 0;
        #1;
        model_reset();
        compare_all();
        check("async_int_low", 8'(int_sig), 8'h00);
        check("async_ready", 8'(host_in_ready), 8'h01);
        check("async_iport", i_port, 8'h00);
        @(negedge clk);
        step();
        rstn = 1;
        step(); step(); step();
        check("post_reset_int", 8'(int_sig), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
